// File: rtl/zx_kbd_pkg.sv
// Shared definitions for the ZX Spectrum PS/2 keyboard front end:
// matrix geometry, scancodes, FSM state types and the scancode lookup.
package zx_kbd_pkg;

    localparam int NUM_ROWS  = 8;
    localparam int NUM_COLS  = 5;
    localparam int NUM_KEYS  = NUM_ROWS * NUM_COLS;
    localparam int NUM_FLAGS = 7;

    // Key index is row*5+col; anything at or above NUM_KEYS means "no key".
    typedef logic [5:0] key_idx_t;
    localparam key_idx_t KEY_NONE = 6'h3F;

    localparam key_idx_t K_CAPS  = 6'd0;
    localparam key_idx_t K_5     = 6'd19;
    localparam key_idx_t K_0     = 6'd20;
    localparam key_idx_t K_8     = 6'd22;
    localparam key_idx_t K_7     = 6'd23;
    localparam key_idx_t K_6     = 6'd24;
    localparam key_idx_t K_SPACE = 6'd35;
    localparam key_idx_t K_SYM   = 6'd36;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_F12    = 8'h07;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    // Keys that press two matrix keys at once, plus F12 which drives reset_req.
    typedef enum logic [2:0] {
        CF_BKSP, CF_LEFT, CF_DOWN, CF_UP, CF_RIGHT, CF_ESC, CF_F12, CF_NONE
    } comp_flag_e;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    typedef enum logic [2:0] {
        DEC_IDLE, DEC_BRK, DEC_EXT, DEC_EXT_BRK, DEC_SKIP
    } dec_state_e;

    function automatic key_idx_t key_idx(input int row, input int col);
        return key_idx_t'(row * NUM_COLS + col);
    endfunction

    // Direct scancode to matrix key; extended codes only map right Ctrl.
    function automatic key_idx_t scan_to_key(input logic [7:0] code, input logic ext);
        key_idx_t k;
        k = KEY_NONE;
        if (ext) begin
            if (code == SC_CTRL) k = K_SYM;
        end else begin
            case (code)
                SC_LSHIFT, SC_RSHIFT: k = K_CAPS;
                8'h1A: k = key_idx(0, 1);  8'h22: k = key_idx(0, 2);
                8'h21: k = key_idx(0, 3);  8'h2A: k = key_idx(0, 4);
                8'h1C: k = key_idx(1, 0);  8'h1B: k = key_idx(1, 1);
                8'h23: k = key_idx(1, 2);  8'h2B: k = key_idx(1, 3);
                8'h34: k = key_idx(1, 4);
                8'h15: k = key_idx(2, 0);  8'h1D: k = key_idx(2, 1);
                8'h24: k = key_idx(2, 2);  8'h2D: k = key_idx(2, 3);
                8'h2C: k = key_idx(2, 4);
                8'h16: k = key_idx(3, 0);  8'h1E: k = key_idx(3, 1);
                8'h26: k = key_idx(3, 2);  8'h25: k = key_idx(3, 3);
                8'h2E: k = K_5;
                8'h45: k = K_0;            8'h46: k = key_idx(4, 1);
                8'h3E: k = K_8;            8'h3D: k = K_7;
                8'h36: k = K_6;
                8'h4D: k = key_idx(5, 0);  8'h44: k = key_idx(5, 1);
                8'h43: k = key_idx(5, 2);  8'h3C: k = key_idx(5, 3);
                8'h35: k = key_idx(5, 4);
                SC_ENTER: k = key_idx(6, 0);
                8'h4B: k = key_idx(6, 1);  8'h42: k = key_idx(6, 2);
                8'h3B: k = key_idx(6, 3);  8'h33: k = key_idx(6, 4);
                SC_SPACE: k = K_SPACE;
                SC_CTRL: k = K_SYM;
                8'h3A: k = key_idx(7, 2);  8'h31: k = key_idx(7, 3);
                8'h32: k = key_idx(7, 4);
                default: k = KEY_NONE;
            endcase
        end
        return k;
    endfunction

    // Scancode to composite flag; cursor keys need the E0 prefix.
    function automatic comp_flag_e scan_to_flag(input logic [7:0] code, input logic ext);
        comp_flag_e f;
        f = CF_NONE;
        if (ext) begin
            case (code)
                SC_LEFT:  f = CF_LEFT;
                SC_DOWN:  f = CF_DOWN;
                SC_UP:    f = CF_UP;
                SC_RIGHT: f = CF_RIGHT;
                default:  f = CF_NONE;
            endcase
        end else begin
            case (code)
                SC_BKSP: f = CF_BKSP;
                SC_ESC:  f = CF_ESC;
                SC_F12:  f = CF_F12;
                default: f = CF_NONE;
            endcase
        end
        return f;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: synchronises and de-glitches the pins, shifts in
// 11-bit frames on filtered falling clock edges and flags framing errors.
module ps2_rx
    import zx_kbd_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 20000
) (
    input  logic       clk_vram,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] data,
    output logic       frame_err
);

    localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          clk_meta, clk_sync, dat_meta, dat_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    rx_state_e     state, state_n;
    logic [7:0]    shift, shift_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic          par_ok, par_ok_n;
    logic [TW-1:0] tmo, tmo_n;
    logic          valid_n, err_n;

    // Two-flop synchronisers; idle PS/2 lines are high.
    always_ff @(posedge clk_vram) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
        end
    end

    // Accept a clock level change only after FILTER consecutive differing samples.
    always_ff @(posedge clk_vram) begin
        if (reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER - 1)) begin
            clk_filt <= clk_sync;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign fall = clk_filt && !clk_sync && (filt_cnt == FW'(FILTER - 1));
    assign data = shift;

    // Receiver state register and one-cycle result pulses.
    always_ff @(posedge clk_vram) begin
        if (reset) begin
            state      <= RX_IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            par_ok     <= 1'b0;
            tmo        <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            bit_cnt    <= bit_cnt_n;
            par_ok     <= par_ok_n;
            tmo        <= tmo_n;
            byte_valid <= valid_n;
            frame_err  <= err_n;
        end
    end

    // Frame sequencing; parity verdict is held until the stop bit so one bad frame gives one error.
    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        par_ok_n  = par_ok;
        tmo_n     = (state == RX_IDLE) ? '0 : tmo + 1'b1;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        if (fall) begin
            tmo_n = '0;
            case (state)
                RX_IDLE: begin
                    if (dat_sync) begin
                        err_n = 1'b1;
                    end else begin
                        state_n   = RX_DATA;
                        bit_cnt_n = '0;
                    end
                end
                RX_DATA: begin
                    shift_n   = {dat_sync, shift[7:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state_n = RX_PARITY;
                end
                RX_PARITY: begin
                    par_ok_n = (^shift) ^ dat_sync;
                    state_n  = RX_STOP;
                end
                default: begin
                    state_n = RX_IDLE;
                    if (!dat_sync || !par_ok) err_n = 1'b1;
                    else                      valid_n = 1'b1;
                end
            endcase
        end else if (state != RX_IDLE && tmo == TW'(TIMEOUT - 1)) begin
            state_n = RX_IDLE;
            tmo_n   = '0;
            err_n   = 1'b1;
        end
    end

endmodule

// File: rtl/zx_keyboard.sv
// PS/2 keyboard to ZX Spectrum key matrix, answering half-row reads on port 0xFE.
module zx_keyboard
    import zx_kbd_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 20000
) (
    input  logic       clk_vram,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic [7:0] A_hi,
    output logic [4:0] key_row,
    output logic       pressed,
    output logic       reset_req,
    output logic       frame_err
);

    logic                 byte_valid;
    logic [7:0]           rx_byte;
    dec_state_e           dec, dec_n;
    logic [2:0]           skip_cnt, skip_n;
    logic                 apply, brk, ext;
    key_idx_t             key_hit;
    logic [2:0]           flag_code;
    logic [NUM_KEYS-1:0]  direct, eff;
    logic [NUM_FLAGS-1:0] flags;
    logic [4:0]           row_acc;

    ps2_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) u_rx (
        .clk_vram   (clk_vram),
        .reset      (reset),
        .ps2_clk    (PS2_CLK),
        .ps2_dat    (PS2_DAT),
        .byte_valid (byte_valid),
        .data       (rx_byte),
        .frame_err  (frame_err)
    );

    assign key_hit   = scan_to_key(rx_byte, ext);
    assign flag_code = scan_to_flag(rx_byte, ext);

    // Prefix decoder state and Pause-sequence skip counter.
    always_ff @(posedge clk_vram) begin
        if (reset) begin
            dec      <= DEC_IDLE;
            skip_cnt <= '0;
        end else begin
            dec      <= dec_n;
            skip_cnt <= skip_n;
        end
    end

    // Track F0/E0 prefixes, swallow the Pause tail, and decide when a byte is a make or break.
    always_comb begin
        dec_n  = dec;
        skip_n = skip_cnt;
        apply  = 1'b0;
        brk    = (dec == DEC_BRK) || (dec == DEC_EXT_BRK);
        ext    = (dec == DEC_EXT) || (dec == DEC_EXT_BRK);
        if (byte_valid) begin
            if (dec == DEC_SKIP) begin
                skip_n = skip_cnt - 1'b1;
                if (skip_cnt == 3'd1) dec_n = DEC_IDLE;
            end else if (rx_byte == SC_PAUSE) begin
                dec_n  = DEC_SKIP;
                skip_n = 3'd7;
            end else if (rx_byte == SC_BREAK && dec == DEC_IDLE) begin
                dec_n = DEC_BRK;
            end else if (rx_byte == SC_BREAK && dec == DEC_EXT) begin
                dec_n = DEC_EXT_BRK;
            end else if (rx_byte == SC_EXT && dec == DEC_IDLE) begin
                dec_n = DEC_EXT;
            end else begin
                apply = 1'b1;
                dec_n = DEC_IDLE;
            end
        end
    end

    // Direct key bits and composite flags; repeated makes just rewrite the same 1.
    always_ff @(posedge clk_vram) begin
        if (reset) begin
            direct <= '0;
            flags  <= '0;
        end else if (apply) begin
            for (int i = 0; i < NUM_KEYS; i++)
                if (key_hit == key_idx_t'(i)) direct[i] <= !brk;
            for (int i = 0; i < NUM_FLAGS; i++)
                if (flag_code == 3'(i)) flags[i] <= !brk;
        end
    end

    // Effective matrix: composite keys OR their pair into the direct bits.
    always_comb begin
        eff = direct;
        if (flags[CF_BKSP])  begin eff[K_CAPS] = 1'b1; eff[K_0]     = 1'b1; end
        if (flags[CF_LEFT])  begin eff[K_CAPS] = 1'b1; eff[K_5]     = 1'b1; end
        if (flags[CF_DOWN])  begin eff[K_CAPS] = 1'b1; eff[K_6]     = 1'b1; end
        if (flags[CF_UP])    begin eff[K_CAPS] = 1'b1; eff[K_7]     = 1'b1; end
        if (flags[CF_RIGHT]) begin eff[K_CAPS] = 1'b1; eff[K_8]     = 1'b1; end
        if (flags[CF_ESC])   begin eff[K_CAPS] = 1'b1; eff[K_SPACE] = 1'b1; end
    end

    // Half-row read: every selected row contributes, result is active-low.
    always_comb begin
        row_acc = '0;
        for (int r = 0; r < NUM_ROWS; r++)
            if (!A_hi[r]) row_acc = row_acc | eff[r*NUM_COLS +: NUM_COLS];
        key_row = ~row_acc;
    end

    // Registered status outputs.
    always_ff @(posedge clk_vram) begin
        if (reset) begin
            pressed   <= 1'b0;
            reset_req <= 1'b0;
        end else begin
            pressed   <= |eff;
            reset_req <= flags[CF_F12];
        end
    end

endmodule

// File: tb/tb_zx_keyboard.sv
// Directed bench for zx_keyboard: drives PS/2 frames and checks port 0xFE reads.
module tb_zx_keyboard;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 20;

    logic       clk_vram = 1'b0;
    logic       reset;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] A_hi;
    logic [4:0] key_row;
    logic       pressed;
    logic       reset_req;
    logic       frame_err;

    int checks    = 0;
    int failures  = 0;
    int errPulses = 0;
    int errBefore;

    zx_keyboard #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk_vram  (clk_vram),
        .reset     (reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .A_hi      (A_hi),
        .key_row   (key_row),
        .pressed   (pressed),
        .reset_req (reset_req),
        .frame_err (frame_err)
    );

    always #5 clk_vram = ~clk_vram;

    // Count frame error pulses away from the active edge.
    always @(negedge clk_vram) begin
        if (frame_err) errPulses++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_vram);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Send the first nBits of an 11-bit frame (start, data LSB first, odd parity, stop).
    task automatic applyStimulus(input logic [7:0] code, input logic badParity, input int nBits);
        logic [10:0] frame;
        frame = {1'b1, (~(^code)) ^ badParity, code, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            PS2_DAT = frame[i];
            waitCycles(HALF);
            PS2_CLK = 1'b0;
            waitCycles(HALF);
            PS2_CLK = 1'b1;
        end
        PS2_DAT = 1'b1;
        waitCycles(2 * HALF);
    endtask

    task automatic sendByte(input logic [7:0] code);
        applyStimulus(code, 1'b0, 11);
    endtask

    task automatic checkRow(input string tag, input logic [7:0] sel, input logic [4:0] expected);
        A_hi = sel;
        #1;
        checkOutput(tag, 8'(key_row), 8'(expected));
    endtask

    initial begin
        reset   = 1'b1;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        A_hi    = 8'h00;
        waitCycles(5);
        checkOutput("reset_key_row", 8'(key_row), 8'h1F);
        checkOutput("reset_pressed", 8'(pressed), 8'h00);
        checkOutput("reset_reset_req", 8'(reset_req), 8'h00);
        checkOutput("reset_frame_err", 8'(frame_err), 8'h00);
        reset = 1'b0;
        waitCycles(5);

        // A make / break
        sendByte(8'h1C);
        checkRow("a_make_row1", 8'hFD, 5'h1E);
        checkOutput("a_make_pressed", 8'(pressed), 8'h01);
        checkRow("a_make_row0", 8'hFE, 5'h1F);
        sendByte(8'hF0); sendByte(8'h1C);
        checkRow("a_break_row1", 8'hFD, 5'h1F);
        checkOutput("a_break_pressed", 8'(pressed), 8'h00);

        // Shift + Z
        sendByte(8'h12); sendByte(8'h1A);
        checkRow("shift_z_row0", 8'hFE, 5'h1C);
        sendByte(8'hF0); sendByte(8'h12);
        checkRow("shift_brk_row0", 8'hFE, 5'h1D);
        sendByte(8'hF0); sendByte(8'h1A);
        checkRow("z_brk_row0", 8'hFE, 5'h1F);

        // Backspace composite and its interaction with Shift
        sendByte(8'h66);
        checkRow("bksp_rows04", 8'hEE, 5'h1E);
        sendByte(8'h12);
        sendByte(8'hF0); sendByte(8'h66);
        checkRow("bksp_brk_row0", 8'hFE, 5'h1E);
        checkRow("bksp_brk_row4", 8'hEF, 5'h1F);
        sendByte(8'hF0); sendByte(8'h12);
        checkRow("shift2_brk_row0", 8'hFE, 5'h1F);

        // Cursor up, release, and keypad 8 without prefix
        sendByte(8'hE0); sendByte(8'h75);
        checkRow("up_row0", 8'hFE, 5'h1E);
        checkRow("up_row4", 8'hEF, 5'h17);
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
        checkRow("up_brk_all", 8'h00, 5'h1F);
        sendByte(8'h75);
        checkRow("kp8_all", 8'h00, 5'h1F);
        checkOutput("kp8_pressed", 8'(pressed), 8'h00);

        // Bad parity
        errBefore = errPulses;
        applyStimulus(8'h1C, 1'b1, 11);
        checkOutput("parity_err_count", 8'(errPulses - errBefore), 8'h01);
        checkRow("parity_row1", 8'hFD, 5'h1F);

        // Timeout after four bits, then recovery
        errBefore = errPulses;
        applyStimulus(8'h1C, 1'b0, 4);
        waitCycles(TIMEOUT + 100);
        checkOutput("timeout_err_count", 8'(errPulses - errBefore), 8'h01);
        sendByte(8'h1C);
        checkRow("recover_row1", 8'hFD, 5'h1E);
        sendByte(8'hF0); sendByte(8'h1C);
        checkRow("recover_brk_row1", 8'hFD, 5'h1F);

        // Pause sequence swallows seven bytes
        sendByte(8'hE1);
        sendByte(8'h1C); sendByte(8'h77); sendByte(8'hE1); sendByte(8'hF0);
        sendByte(8'h14); sendByte(8'hF0); sendByte(8'h77);
        checkRow("pause_all", 8'h00, 5'h1F);
        checkOutput("pause_pressed", 8'(pressed), 8'h00);

        // F12 reset request
        sendByte(8'h07);
        checkOutput("f12_make", 8'(reset_req), 8'h01);
        sendByte(8'hF0); sendByte(8'h07);
        checkOutput("f12_break", 8'(reset_req), 8'h00);

        // Reset mid-prefix and mid-frame
        sendByte(8'h1C);
        sendByte(8'h07);
        sendByte(8'hE0);
        applyStimulus(8'h1C, 1'b0, 5);
        reset = 1'b1;
        waitCycles(3);
        checkRow("midreset_all", 8'h00, 5'h1F);
        checkOutput("midreset_pressed", 8'(pressed), 8'h00);
        checkOutput("midreset_reset_req", 8'(reset_req), 8'h00);
        checkOutput("midreset_frame_err", 8'(frame_err), 8'h00);
        reset = 1'b0;
        errBefore = errPulses;
        waitCycles(TIMEOUT + 100);
        checkOutput("midreset_no_err", 8'(errPulses - errBefore), 8'h00);
        sendByte(8'h1C);
        checkRow("postreset_row1", 8'hFD, 5'h1E);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
